// File: rtl/lv_owt_pkg.sv
// Shared types and constants for the LV-side one-wire transmit engine.
package lv_owt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_HEAD,
    ST_SYNC_TAIL,
    ST_CMD,
    ST_DATA,
    ST_CRC,
    ST_END_TAIL,
    ST_WAIT_ACK
  } owt_tx_st_e;

  typedef enum logic {
    OWN_SPI,
    OWN_WDG
  } owt_owner_e;

  localparam int unsigned CRC_W      = 8;
  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;
  localparam int unsigned SLOT_CNT_W = 16;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial MSB-first CRC8; i_init restarts from zero with the current bit.
module crc8_serial
  import lv_owt_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC8_POLY
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_init,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_base;
  logic [CRC_W-1:0] w_nxt;
  logic             w_fb;

  always_comb begin
    w_base = i_init ? '0 : r_crc;
    w_fb   = w_base[CRC_W-1] ^ i_bit;
    w_nxt  = {w_base[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= w_nxt;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/lv_owt_tx_engine.sv
// LV-side OWT transmit engine: arbitrates SPI/watchdog requests and sends one
// Manchester frame per request with ACK timeout, bounded retry and abort.
module lv_owt_tx_engine
  import lv_owt_pkg::*;
#(
  parameter int unsigned       REG_AW        = 7,
  parameter int unsigned       REG_DW        = 8,
  parameter int unsigned       HALF_CYC      = 12,
  parameter int unsigned       SYNC_BIT_NUM  = 4,
  parameter int unsigned       TAIL_HALF_NUM = 4,
  parameter int unsigned       ACK_TMO_CYC   = 512,
  parameter int unsigned       MAX_RETRY     = 2,
  parameter logic [REG_AW-1:0] ADC_ADDR      = 7'h7F
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_owt_wen,
  input  logic              i_spi_owt_ren,
  input  logic [REG_AW-1:0] i_spi_owt_addr,
  input  logic [REG_DW-1:0] i_spi_owt_wdata,
  output logic              o_spi_owt_done,
  output logic              o_spi_owt_err,
  input  logic              i_wdg_owt_req_adc,
  output logic              o_owt_wdg_ack_adc,
  output logic              o_owt_wdg_err_adc,
  input  logic              i_abort,
  input  logic              i_owt_rx_ack,
  input  logic              i_owt_rx_status,
  output logic              o_lv_hv_owt_tx,
  output logic              o_owt_busy
);

  localparam int unsigned CMD_W   = 1 + REG_AW;
  localparam int unsigned FRM_W   = CMD_W + REG_DW;
  localparam int unsigned TMR_MAX = (ACK_TMO_CYC > HALF_CYC) ? ACK_TMO_CYC : HALF_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 1) + 1;

  owt_tx_st_e              r_state, w_state_nxt;
  owt_owner_e              r_owner, w_owner_nxt;
  logic [SLOT_CNT_W-1:0]   r_half, w_half_nxt, w_last, w_idx;
  logic [TMR_W-1:0]        r_tmr, w_tmr_nxt;
  logic [RTY_W-1:0]        r_retry, w_retry_nxt;
  logic                    r_abort, w_abort_nxt;
  logic [CMD_W-1:0]        r_cmd, w_cmd_nxt;
  logic [REG_DW-1:0]       r_data, w_data_nxt;
  logic                    r_tx, r_busy;
  logic                    r_spi_done, r_spi_err, r_wdg_ack, r_wdg_err;
  logic                    w_done, w_err, w_slot_end, w_slot_adv, w_req, w_pulse;
  logic                    w_bit, w_tx_nxt;
  logic [FRM_W-1:0]        w_frame, w_frame_sh;
  logic [CRC_W-1:0]        w_crc, w_crc_sh;
  logic                    w_crc_en, w_crc_init;

  // Last half-bit slot index of the current serialising state.
  always_comb begin
    w_last = '0;
    case (r_state)
      ST_SYNC_HEAD: w_last = SLOT_CNT_W'(2 * SYNC_BIT_NUM - 1);
      ST_SYNC_TAIL: w_last = SLOT_CNT_W'(TAIL_HALF_NUM - 1);
      ST_CMD:       w_last = SLOT_CNT_W'(2 * CMD_W - 1);
      ST_DATA:      w_last = SLOT_CNT_W'(2 * REG_DW - 1);
      ST_CRC:       w_last = SLOT_CNT_W'(2 * CRC_W - 1);
      ST_END_TAIL:  w_last = SLOT_CNT_W'(TAIL_HALF_NUM - 1);
      default:      w_last = '0;
    endcase
  end

  // Next-state, timers, accept and ack/retry decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_half_nxt  = r_half;
    w_tmr_nxt   = r_tmr;
    w_retry_nxt = r_retry;
    w_abort_nxt = r_abort;
    w_cmd_nxt   = r_cmd;
    w_data_nxt  = r_data;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_slot_adv  = 1'b0;
    w_slot_end  = (r_tmr == TMR_W'(HALF_CYC - 1));
    w_req       = i_wdg_owt_req_adc | i_spi_owt_wen | i_spi_owt_ren;
    w_pulse     = r_spi_done | r_spi_err | r_wdg_ack | r_wdg_err;

    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt  = '0;
        w_half_nxt = '0;
        // A pulse still on the outputs means the owner has not yet dropped its level.
        if (w_req && !w_pulse) begin
          w_state_nxt = ST_SYNC_HEAD;
          w_retry_nxt = '0;
          w_abort_nxt = 1'b0;
          if (i_wdg_owt_req_adc) begin
            w_owner_nxt = OWN_WDG;
            w_cmd_nxt   = {1'b0, ADC_ADDR};
            w_data_nxt  = '0;
          end else if (i_spi_owt_wen) begin
            w_owner_nxt = OWN_SPI;
            w_cmd_nxt   = {1'b1, i_spi_owt_addr};
            w_data_nxt  = i_spi_owt_wdata;
          end else begin
            w_owner_nxt = OWN_SPI;
            w_cmd_nxt   = {1'b0, i_spi_owt_addr};
            w_data_nxt  = '0;
          end
        end
      end
      ST_WAIT_ACK: begin
        w_tmr_nxt = r_tmr + 1'b1;
        if (i_owt_rx_ack && !i_owt_rx_status) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_owt_rx_ack || (r_tmr == TMR_W'(ACK_TMO_CYC - 1))) begin
          if (r_retry < RTY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = ST_SYNC_HEAD;
            w_tmr_nxt   = '0;
            w_half_nxt  = '0;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        if (r_state != ST_END_TAIL && i_abort) w_abort_nxt = 1'b1;
        w_tmr_nxt = r_tmr + 1'b1;
        if (w_slot_end) begin
          w_tmr_nxt  = '0;
          w_slot_adv = 1'b1;
          w_half_nxt = r_half + 1'b1;
          if (r_state != ST_END_TAIL && w_abort_nxt) begin
            w_state_nxt = ST_END_TAIL;
            w_half_nxt  = '0;
          end else if (r_half == w_last) begin
            w_half_nxt = '0;
            case (r_state)
              ST_SYNC_HEAD: w_state_nxt = ST_SYNC_TAIL;
              ST_SYNC_TAIL: w_state_nxt = ST_CMD;
              ST_CMD:       w_state_nxt = ST_DATA;
              ST_DATA:      w_state_nxt = ST_CRC;
              ST_CRC:       w_state_nxt = ST_END_TAIL;
              default: begin
                if (r_abort) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
                end else begin
                  w_state_nxt = ST_WAIT_ACK;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  // Line level for the slot that starts at the next edge.
  always_comb begin
    w_frame    = {r_cmd, r_data};
    w_idx      = w_half_nxt >> 1;
    w_frame_sh = '0;
    w_crc_sh   = w_crc << w_idx;
    w_bit      = 1'b0;
    case (w_state_nxt)
      ST_CMD: begin
        w_frame_sh = w_frame << w_idx;
        w_bit      = w_frame_sh[FRM_W-1];
      end
      ST_DATA: begin
        w_frame_sh = w_frame << (w_idx + SLOT_CNT_W'(CMD_W));
        w_bit      = w_frame_sh[FRM_W-1];
      end
      ST_CRC:  w_bit = w_crc_sh[CRC_W-1];
      default: w_bit = 1'b0;
    endcase

    case (w_state_nxt)
      ST_SYNC_HEAD:          w_tx_nxt = w_half_nxt[0];
      ST_SYNC_TAIL:          w_tx_nxt = 1'b1;
      ST_CMD, ST_DATA, ST_CRC: w_tx_nxt = w_bit ^ w_half_nxt[0];
      default:               w_tx_nxt = 1'b0;
    endcase

    w_crc_en   = w_slot_adv && !w_half_nxt[0] &&
                 (w_state_nxt == ST_CMD || w_state_nxt == ST_DATA);
    w_crc_init = (w_state_nxt == ST_CMD) && (w_half_nxt == '0);
  end

  crc8_serial #(.POLY(CRC8_POLY)) u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_crc_en),
    .i_init  (w_crc_init),
    .i_bit   (w_bit),
    .o_crc   (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_SPI;
      r_half     <= '0;
      r_tmr      <= '0;
      r_retry    <= '0;
      r_abort    <= 1'b0;
      r_cmd      <= '0;
      r_data     <= '0;
      r_tx       <= 1'b0;
      r_busy     <= 1'b0;
      r_spi_done <= 1'b0;
      r_spi_err  <= 1'b0;
      r_wdg_ack  <= 1'b0;
      r_wdg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_half     <= w_half_nxt;
      r_tmr      <= w_tmr_nxt;
      r_retry    <= w_retry_nxt;
      r_abort    <= w_abort_nxt;
      r_cmd      <= w_cmd_nxt;
      r_data     <= w_data_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_spi_done <= w_done && (r_owner == OWN_SPI);
      r_spi_err  <= w_err  && (r_owner == OWN_SPI);
      r_wdg_ack  <= w_done && (r_owner == OWN_WDG);
      r_wdg_err  <= w_err  && (r_owner == OWN_WDG);
    end
  end

  assign o_lv_hv_owt_tx    = r_tx;
  assign o_owt_busy        = r_busy;
  assign o_spi_owt_done    = r_spi_done;
  assign o_spi_owt_err     = r_spi_err;
  assign o_owt_wdg_ack_adc = r_wdg_ack;
  assign o_owt_wdg_err_adc = r_wdg_err;

endmodule

// File: tb/tb_lv_owt_tx_engine.sv
// Directed bench for lv_owt_tx_engine: frame content, retry, arbitration, abort, reset.
module tb_lv_owt_tx_engine;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_spi_owt_wen, i_spi_owt_ren;
  logic [6:0] i_spi_owt_addr;
  logic [7:0] i_spi_owt_wdata;
  logic       o_spi_owt_done, o_spi_owt_err;
  logic       i_wdg_owt_req_adc;
  logic       o_owt_wdg_ack_adc, o_owt_wdg_err_adc;
  logic       i_abort, i_owt_rx_ack, i_owt_rx_status;
  logic       o_lv_hv_owt_tx, o_owt_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_spi_done = 0, n_spi_err = 0, n_adc_ack = 0, n_adc_err = 0;

  always #5 i_clk = ~i_clk;

  lv_owt_tx_engine dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_spi_owt_wen     (i_spi_owt_wen),
    .i_spi_owt_ren     (i_spi_owt_ren),
    .i_spi_owt_addr    (i_spi_owt_addr),
    .i_spi_owt_wdata   (i_spi_owt_wdata),
    .o_spi_owt_done    (o_spi_owt_done),
    .o_spi_owt_err     (o_spi_owt_err),
    .i_wdg_owt_req_adc (i_wdg_owt_req_adc),
    .o_owt_wdg_ack_adc (o_owt_wdg_ack_adc),
    .o_owt_wdg_err_adc (o_owt_wdg_err_adc),
    .i_abort           (i_abort),
    .i_owt_rx_ack      (i_owt_rx_ack),
    .i_owt_rx_status   (i_owt_rx_status),
    .o_lv_hv_owt_tx    (o_lv_hv_owt_tx),
    .o_owt_busy        (o_owt_busy)
  );

  always @(posedge i_clk) begin
    if (o_spi_owt_done)    n_spi_done++;
    if (o_spi_owt_err)     n_spi_err++;
    if (o_owt_wdg_ack_adc) n_adc_ack++;
    if (o_owt_wdg_err_adc) n_adc_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [15:0] m);
    logic [7:0] c;
    logic [7:0] b [2];
    b[0] = m[15:8];
    b[1] = m[7:0];
    c = 8'h00;
    for (int k = 0; k < 2; k++) begin
      c = c ^ b[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // One slot per bit, slot 0 at bit 63.
  function automatic logic [63:0] build_frame(input logic [7:0] cmd, input logic [7:0] dat);
    logic [63:0] f;
    logic [23:0] pl;
    int p;
    pl = {cmd, dat, crc8({cmd, dat})};
    f = '0;
    p = 63;
    for (int i = 0; i < 4; i++) begin f[p] = 1'b0; f[p-1] = 1'b1; p -= 2; end
    for (int i = 0; i < 4; i++) begin f[p] = 1'b1; p -= 1; end
    for (int i = 23; i >= 0; i--) begin f[p] = pl[i]; f[p-1] = ~pl[i]; p -= 2; end
    return f;
  endfunction

  task automatic wait_busy(output int waited);
    waited = 0;
    while (!o_owt_busy && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
  endtask

  task automatic capture(input int pre_wait, input int nslots, input int abort_slot,
                         output logic [63:0] bits, output int unstable);
    logic v0;
    bits = '0;
    unstable = 0;
    v0 = 1'b0;
    repeat (pre_wait) @(negedge i_clk);
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < 12; c++) begin
        if (s != 0 || c != 0) @(negedge i_clk);
        if (c == 0) begin
          v0 = o_lv_hv_owt_tx;
          bits[63-s] = v0;
        end else if (o_lv_hv_owt_tx !== v0) begin
          unstable++;
        end
        i_abort = (s == abort_slot && c == 5);
      end
    end
    i_abort = 1'b0;
  endtask

  task automatic send_ack(input logic status);
    i_owt_rx_ack = 1'b1;
    i_owt_rx_status = status;
    @(negedge i_clk);
    i_owt_rx_ack = 1'b0;
    i_owt_rx_status = 1'b0;
  endtask

  logic [63:0] f1, f2, f3, exp;
  int un1, un2, un3, w;

  initial begin
    i_rst_n = 1'b0;
    i_spi_owt_wen = 1'b0; i_spi_owt_ren = 1'b0;
    i_spi_owt_addr = '0; i_spi_owt_wdata = '0;
    i_wdg_owt_req_adc = 1'b0; i_abort = 1'b0;
    i_owt_rx_ack = 1'b0; i_owt_rx_status = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 64'({o_lv_hv_owt_tx, o_owt_busy, o_spi_owt_done, o_spi_owt_err,
                              o_owt_wdg_ack_adc, o_owt_wdg_err_adc}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_after_reset", 64'({o_lv_hv_owt_tx, o_owt_busy}), 64'd0);

    // SPI write 0x15/0xA5, ack after 100 clocks
    i_spi_owt_addr = 7'h15; i_spi_owt_wdata = 8'hA5; i_spi_owt_wen = 1'b1;
    wait_busy(w);
    chk("t1_accept_latency", 64'(w), 64'd1);
    capture(0, 64, -1, f1, un1);
    chk("t1_frame", f1, build_frame(8'h95, 8'hA5));
    chk("t1_stable", 64'(un1), 64'd0);
    repeat (100) @(negedge i_clk);
    chk("t1_busy_wait_ack", 64'(o_owt_busy), 64'd1);
    send_ack(1'b0);
    chk("t1_done_pulse", 64'({o_spi_owt_done, o_spi_owt_err, o_owt_busy}), 64'b100);
    i_spi_owt_wen = 1'b0;
    @(negedge i_clk);
    chk("t1_done_one_cycle", 64'(o_spi_owt_done), 64'd0);
    chk("t1_counts", 64'({n_spi_done, n_spi_err}), {32'd1, 32'd0});

    // SPI read 0x02 with no ack: three identical frames then err
    i_spi_owt_addr = 7'h02; i_spi_owt_ren = 1'b1;
    wait_busy(w);
    capture(0, 64, -1, f1, un1);
    capture(513, 64, -1, f2, un2);
    capture(513, 64, -1, f3, un3);
    exp = build_frame(8'h02, 8'h00);
    chk("t2_frame1", f1, exp);
    chk("t2_frame2", f2, exp);
    chk("t2_frame3", f3, exp);
    chk("t2_stable", 64'(un1 + un2 + un3), 64'd0);
    repeat (512) @(negedge i_clk);
    chk("t2_busy_before_err", 64'({o_owt_busy, o_spi_owt_err}), 64'b10);
    @(negedge i_clk);
    chk("t2_err_pulse", 64'({o_spi_owt_err, o_owt_busy, o_spi_owt_done}), 64'b100);
    i_spi_owt_ren = 1'b0;
    @(negedge i_clk);
    chk("t2_counts", 64'({n_spi_done, n_spi_err}), {32'd1, 32'd1});

    // watchdog and SPI write together: ADC frame first, then SPI frame
    i_spi_owt_addr = 7'h33; i_spi_owt_wdata = 8'h5A;
    i_spi_owt_wen = 1'b1; i_wdg_owt_req_adc = 1'b1;
    wait_busy(w);
    capture(0, 64, -1, f1, un1);
    chk("t3_adc_frame", f1, build_frame(8'h7F, 8'h00));
    repeat (10) @(negedge i_clk);
    send_ack(1'b0);
    chk("t3_adc_ack", 64'({o_owt_wdg_ack_adc, o_spi_owt_done}), 64'b10);
    i_wdg_owt_req_adc = 1'b0;
    wait_busy(w);
    chk("t3_gap_after_pulse", 64'(w), 64'd2);
    capture(0, 64, -1, f2, un2);
    chk("t3_spi_frame", f2, build_frame(8'hB3, 8'h5A));
    chk("t3_stable", 64'(un1 + un2), 64'd0);
    repeat (10) @(negedge i_clk);
    send_ack(1'b0);
    chk("t3_spi_done", 64'({o_spi_owt_done, o_owt_wdg_ack_adc}), 64'b10);
    i_spi_owt_wen = 1'b0;
    @(negedge i_clk);
    chk("t3_counts", 64'({n_adc_ack, n_spi_done}), {32'd1, 32'd2});

    // abort mid-DATA: slot 30 completes, 4 low tail slots, err, no retry
    i_spi_owt_addr = 7'h40; i_spi_owt_wdata = 8'h3C; i_spi_owt_wen = 1'b1;
    wait_busy(w);
    capture(0, 35, 30, f1, un1);
    exp = build_frame(8'hC0, 8'h3C);
    chk("t4_abort_frame", f1, {exp[63:33], 33'd0});
    chk("t4_stable", 64'(un1), 64'd0);
    @(negedge i_clk);
    chk("t4_err_pulse", 64'({o_spi_owt_err, o_owt_busy, o_lv_hv_owt_tx}), 64'b100);
    i_spi_owt_wen = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("t4_no_retry", 64'(o_owt_busy), 64'd0);
    chk("t4_counts", 64'({n_spi_done, n_spi_err}), {32'd2, 32'd2});

    // NACK then ack on retry: exactly two frames, one done
    i_spi_owt_addr = 7'h7A; i_spi_owt_wdata = 8'h01; i_spi_owt_wen = 1'b1;
    wait_busy(w);
    capture(0, 64, -1, f1, un1);
    repeat (20) @(negedge i_clk);
    send_ack(1'b1);
    capture(0, 64, -1, f2, un2);
    exp = build_frame(8'hFA, 8'h01);
    chk("t5_frame1", f1, exp);
    chk("t5_frame_retry", f2, exp);
    chk("t5_stable", 64'(un1 + un2), 64'd0);
    repeat (30) @(negedge i_clk);
    send_ack(1'b0);
    chk("t5_done", 64'({o_spi_owt_done, o_spi_owt_err}), 64'b10);
    i_spi_owt_wen = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("t5_idle", 64'(o_owt_busy), 64'd0);
    chk("t5_counts", 64'({n_spi_done, n_spi_err}), {32'd3, 32'd2});

    // reset mid-CMD, then a fresh full frame
    i_spi_owt_addr = 7'h11; i_spi_owt_wdata = 8'h22; i_spi_owt_wen = 1'b1;
    wait_busy(w);
    repeat (12 * 12 + 3) @(negedge i_clk);
    chk("t6_line_high_in_cmd", 64'(o_lv_hv_owt_tx), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("t6_reset_line_busy", 64'({o_lv_hv_owt_tx, o_owt_busy, o_spi_owt_done, o_spi_owt_err}), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_busy(w);
    capture(0, 64, -1, f1, un1);
    chk("t6_fresh_frame", f1, build_frame(8'h91, 8'h22));
    chk("t6_stable", 64'(un1), 64'd0);
    repeat (5) @(negedge i_clk);
    send_ack(1'b0);
    chk("t6_done", 64'(o_spi_owt_done), 64'd1);
    i_spi_owt_wen = 1'b0;
    @(negedge i_clk);
    chk("final_counts", {8'(n_spi_done), 8'(n_spi_err), 8'(n_adc_ack), 8'(n_adc_err), 32'd0},
        {8'd4, 8'd2, 8'd1, 8'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
